regfile_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one register-file write port among NUM_REQ requesters, such as execution units and load return. The register bank behind the port is built from D_FF storage bits. The block picks one pending request per cycle, registers the winner's address and data onto the write port, and returns a one-cycle acknowledge to the winner. It sits between the writeback sources and the register bank and owns all write-port sequencing.

---
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// The winner's address/data are registered onto the port together with a one-cycle acknowledge.
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_stall,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0]  wrData_q, wrData_d;
    logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;

    logic [NUM_REQ-1:0] elig;
    logic               grantValid;
    logic [PTR_W-1:0]   winner;

    // The requester currently being acked still shows its old request, so it sits out this cycle.
    assign elig = req & ~ack_q;
    assign busy = |elig;

    // Two downward scans: the second (indices at or above the pointer) overrides the first,
    // so the lowest index at/after rrPtr_q wins, falling back to the lowest wrapped index.
    always_comb begin
        grantValid = 1'b0;
        winner     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i] && (PTR_W'(i) < rrPtr_q)) begin
                grantValid = 1'b1;
                winner     = PTR_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i] && (PTR_W'(i) >= rrPtr_q)) begin
                grantValid = 1'b1;
                winner     = PTR_W'(i);
            end
        end
    end

    always_comb begin
        ack_d    = '0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        rrPtr_d  = rrPtr_q;
        if (!wr_stall && grantValid) begin
            ack_d   = NUM_REQ'(1) << winner;
            rrPtr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (PTR_W'(i) == winner) begin
                    wrAddr_d = req_addr[i*ADDR_W +: ADDR_W];
                    wrData_d = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q    <= '0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            rrPtr_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            rrPtr_q  <= rrPtr_d;
        end
    end

    // Write enable is derived from the one-hot ack so the two can never disagree.
    assign ack     = ack_q;
    assign wr_en   = |ack_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, round-robin order, self-masking, stall and
// asynchronous reset during a write, all against hand-computed expectations.
module tb_regfile_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wr_stall;
    logic [NUM_REQ-1:0]        ack;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;

    logic [ADDR_W-1:0] addrTab [NUM_REQ];
    logic [DATA_W-1:0] dataTab [NUM_REQ];

    int assertCount = 0;
    int failCount   = 0;

    regfile_wr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .wr_stall(wr_stall),
        .ack     (ack),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-requester tables onto the flat request buses.
    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = addrTab[i];
            req_data[i*DATA_W +: DATA_W] = dataTab[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic stall);
        req      = r;
        wr_stall = stall;
    endtask

    logic [NUM_REQ-1:0] rrAck [5];
    int                 rrIdx [5];

    initial begin
        reset    = 1'b0;
        req      = '0;
        wr_stall = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addrTab[i] = ADDR_W'(10 + i);
            dataTab[i] = 32'hA000_0000 + DATA_W'(i);
        end
        rrAck[0] = 4'b0001; rrIdx[0] = 0;
        rrAck[1] = 4'b0010; rrIdx[1] = 1;
        rrAck[2] = 4'b0100; rrIdx[2] = 2;
        rrAck[3] = 4'b1000; rrIdx[3] = 3;
        rrAck[4] = 4'b0001; rrIdx[4] = 0;

        // Reset held low with every requester pending.
        applyStimulus(4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst ack",   64'(ack),     64'h0);
            checkOutput("rst wr_en", 64'(wr_en),   64'h0);
            checkOutput("rst addr",  64'(wr_addr), 64'h0);
            checkOutput("rst data",  64'(wr_data), 64'h0);
        end
        reset = 1'b1;

        // All four requesting continuously: strict rotation starting at 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rr ack",   64'(ack),     64'(rrAck[i]));
            checkOutput("rr wr_en", 64'(wr_en),   64'h1);
            checkOutput("rr addr",  64'(wr_addr), 64'(addrTab[rrIdx[i]]));
            checkOutput("rr data",  64'(wr_data), 64'(dataTab[rrIdx[i]]));
            checkOutput("rr busy",  64'(busy),    64'h1);
        end

        // Idle: port goes quiet, address/data hold the last write.
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("idle wr_en", 64'(wr_en),   64'h0);
        checkOutput("idle ack",   64'(ack),     64'h0);
        checkOutput("idle busy",  64'(busy),    64'h0);
        checkOutput("idle addr",  64'(wr_addr), 64'(ADDR_W'(10)));

        // Single request from requester 2.
        addrTab[2] = 5'd7;
        dataTab[2] = 32'hDEADBEEF;
        applyStimulus(4'b0100, 1'b0);
        #1;
        checkOutput("single busy pre", 64'(busy), 64'h1);
        @(negedge clk);
        checkOutput("single ack",  64'(ack),     64'h4);
        checkOutput("single en",   64'(wr_en),   64'h1);
        checkOutput("single addr", 64'(wr_addr), 64'h7);
        checkOutput("single data", 64'(wr_data), 64'hDEADBEEF);
        checkOutput("single busy", 64'(busy),    64'h0);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("single done", 64'(wr_en), 64'h0);

        // Requester 1 re-requests immediately: grants every second cycle only.
        applyStimulus(4'b0010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("selfmask ack", 64'(ack), (i % 2 == 0) ? 64'h2 : 64'h0);
        end

        // Pointer is now 2: requester 2 wins, then reset is pulled between edges.
        applyStimulus(4'b1100, 1'b0);
        @(negedge clk);
        checkOutput("mid ack",   64'(ack),   64'h4);
        checkOutput("mid wr_en", 64'(wr_en), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async wr_en", 64'(wr_en),   64'h0);
        checkOutput("async ack",   64'(ack),     64'h0);
        checkOutput("async addr",  64'(wr_addr), 64'h0);
        applyStimulus(4'b1010, 1'b0);
        @(negedge clk);
        checkOutput("async hold", 64'(wr_en), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post rst ack", 64'(ack), 64'h2);
        applyStimulus(4'b1000, 1'b0);
        @(negedge clk);
        checkOutput("wrap ack", 64'(ack), 64'h8);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("wrap idle", 64'(wr_en), 64'h0);

        // Stall with pointer back at 0: nothing granted until the stall drops.
        applyStimulus(4'b0011, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall wr_en", 64'(wr_en), 64'h0);
            checkOutput("stall ack",   64'(ack),   64'h0);
            checkOutput("stall busy",  64'(busy),  64'h1);
        end
        applyStimulus(4'b0011, 1'b0);
        @(negedge clk);
        checkOutput("unstall ack0", 64'(ack), 64'h1);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkOutput("unstall ack1", 64'(ack), 64'h2);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("final idle", 64'(wr_en), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
